// File: rtl/aes_pkg.sv
// Shared definitions for the AES decryption sequencer.
// Contents:
//   KEY_W / DATA_W   default key and block bus widths
//   AES128..AES256   mode encodings; MODE_ILLEGAL is rejected at accept time
//   state_t          sequencer states
//   nr_of()          number of AES rounds for a mode
package aes_pkg;

  localparam int KEY_W  = 256;
  localparam int DATA_W = 128;

  localparam logic [1:0] AES128       = 2'd0;
  localparam logic [1:0] AES192       = 2'd1;
  localparam logic [1:0] AES256       = 2'd2;
  localparam logic [1:0] MODE_ILLEGAL = 2'd3;

  typedef enum logic [2:0] {
    IDLE,
    KLOAD,
    KFWD,
    KREV,
    DEC,
    OUT
  } state_t;

  // The illegal mode never reaches a running job, so it simply shares the
  // AES-128 round count.
  function automatic logic [4:0] nr_of(input logic [1:0] mode);
    case (mode)
      AES192:  return 5'd12;
      AES256:  return 5'd14;
      default: return 5'd10;
    endcase
  endfunction

endpackage

// File: rtl/aes_seq_counter.sv
// 5-bit loadable up-counter with a terminal-count compare.
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset
//   load        force count to load_val (takes priority over en)
//   load_val    value loaded when load=1
//   en          increment by one
//   term        terminal value to compare against
//   count       current count
//   at_term     count equals term (combinational)
module aes_seq_counter (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [4:0] load_val,
  input  logic       en,
  input  logic [4:0] term,
  output logic [4:0] count,
  output logic       at_term
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= 5'd0;
    end else if (load) begin
      count <= load_val;
    end else if (en) begin
      count <= count + 5'd1;
    end
  end

  assign at_term = (count == term);

endmodule

// File: rtl/aes_inv_sequencer.sv
// Sequencer for one AES decryption: key load, forward key-schedule sweep,
// then a reverse sweep with the inverse cipher running in lock-step.
// Ports:
//   start/start_ready/mode_in/key_in/ct_in  host request handshake
//   ke_load/ke_rev/ke_mode/ke_key/ke_round  key_expansion control and monitor
//   ic_load/ic_en/ic_data/ic_out/ic_done    inv_cipher control and result
//   pt_out/pt_valid/pt_ready                plaintext valid/ready handshake
//   busy, err                               status; err is sticky until next accept
module aes_inv_sequencer #(
  parameter int KEY_W  = aes_pkg::KEY_W,
  parameter int DATA_W = aes_pkg::DATA_W,
  parameter int SLACK  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              start_ready,
  input  logic [1:0]        mode_in,
  input  logic [KEY_W-1:0]  key_in,
  input  logic [DATA_W-1:0] ct_in,
  output logic              ke_load,
  output logic              ke_rev,
  output logic [1:0]        ke_mode,
  output logic [KEY_W-1:0]  ke_key,
  input  logic [4:0]        ke_round,
  output logic              ic_load,
  output logic              ic_en,
  output logic [DATA_W-1:0] ic_data,
  input  logic [DATA_W-1:0] ic_out,
  input  logic              ic_done,
  output logic [DATA_W-1:0] pt_out,
  output logic              pt_valid,
  input  logic              pt_ready,
  output logic              busy,
  output logic              err
);

  import aes_pkg::*;

  state_t            state, state_next;
  logic [1:0]        mode_reg;
  logic [KEY_W-1:0]  key_reg;
  logic [DATA_W-1:0] ct_reg;
  logic [DATA_W-1:0] pt_reg;
  logic              err_reg;
  logic [4:0]        nr;
  logic [4:0]        term;
  logic [4:0]        count;
  logic              at_term;
  logic              cnt_load;
  logic              cnt_en;
  logic              accept;

  assign nr      = nr_of(mode_reg);
  assign accept  = (state == IDLE) && start;
  assign ke_mode = mode_reg;
  assign ke_key  = key_reg;
  assign ic_data = ct_reg;
  assign pt_out  = pt_reg;
  assign err     = err_reg;

  // One counter serves both sweeps. KFWD ends on count L-1 (= Nr); DEC
  // times out on count L+SLACK-1 (= Nr+SLACK), i.e. after L+SLACK cycles.
  aes_seq_counter u_counter (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (cnt_load),
    .load_val (5'd0),
    .en       (cnt_en),
    .term     (term),
    .count    (count),
    .at_term  (at_term)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next  = state;
    start_ready = 1'b0;
    busy        = 1'b1;
    ke_load     = 1'b0;
    ic_load     = 1'b0;
    ke_rev      = 1'b0;
    ic_en       = 1'b0;
    pt_valid    = 1'b0;
    cnt_load    = 1'b0;
    cnt_en      = 1'b0;
    term        = nr;
    case (state)
      IDLE: begin
        start_ready = 1'b1;
        busy        = 1'b0;
        if (start && (mode_in != MODE_ILLEGAL)) begin
          state_next = KLOAD;
        end
      end
      KLOAD: begin
        ke_load    = 1'b1;
        ic_load    = 1'b1;
        cnt_load   = 1'b1;
        state_next = KFWD;
      end
      KFWD: begin
        cnt_en = 1'b1;
        if (at_term) begin
          state_next = KREV;
        end
      end
      KREV: begin
        ke_rev     = 1'b1;
        ic_en      = 1'b1;
        cnt_load   = 1'b1;
        state_next = DEC;
      end
      DEC: begin
        ke_rev = 1'b1;
        ic_en  = 1'b1;
        cnt_en = 1'b1;
        term   = nr + 5'(SLACK);
        // A result arriving on the timeout cycle still counts.
        if (ic_done) begin
          state_next = OUT;
        end else if (at_term) begin
          state_next = IDLE;
        end
      end
      OUT: begin
        ke_rev   = 1'b1;
        pt_valid = 1'b1;
        if (pt_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_reg <= 2'd0;
      key_reg  <= '0;
      ct_reg   <= '0;
      pt_reg   <= '0;
      err_reg  <= 1'b0;
    end else begin
      if (accept) begin
        mode_reg <= mode_in;
        key_reg  <= key_in;
        ct_reg   <= ct_in;
        err_reg  <= (mode_in == MODE_ILLEGAL);
      end else if ((state == DEC) && !ic_done && at_term) begin
        err_reg <= 1'b1;
      end else if ((state == KFWD) && (ke_round > nr)) begin
        // Schedule overrun is flagged only; the job keeps going.
        err_reg <= 1'b1;
      end
      if ((state == DEC) && ic_done) begin
        pt_reg <= ic_out;
      end
    end
  end

endmodule

// File: tb/tb_aes_inv_sequencer.sv
module tb_aes_inv_sequencer;

  localparam int SLACK = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic         start_ready;
  logic [1:0]   mode_in;
  logic [255:0] key_in;
  logic [127:0] ct_in;
  logic         ke_load;
  logic         ke_rev;
  logic [1:0]   ke_mode;
  logic [255:0] ke_key;
  logic [4:0]   ke_round;
  logic         ic_load;
  logic         ic_en;
  logic [127:0] ic_data;
  logic [127:0] ic_out;
  logic         ic_done;
  logic [127:0] pt_out;
  logic         pt_valid;
  logic         pt_ready;
  logic         busy;
  logic         err;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // environment knobs
  bit inj_round = 1'b0;
  bit ic_dead   = 1'b0;
  int ic_extra  = 0;

  localparam logic [255:0] K128  = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
  localparam logic [255:0] K192  = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
  localparam logic [255:0] K256  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] CT128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT192 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [127:0] CT256 = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [127:0] PT    = 128'h00112233445566778899aabbccddeeff;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  aes_inv_sequencer #(.KEY_W(256), .DATA_W(128), .SLACK(SLACK)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .start_ready(start_ready),
    .mode_in(mode_in), .key_in(key_in), .ct_in(ct_in),
    .ke_load(ke_load), .ke_rev(ke_rev), .ke_mode(ke_mode), .ke_key(ke_key),
    .ke_round(ke_round), .ic_load(ic_load), .ic_en(ic_en), .ic_data(ic_data),
    .ic_out(ic_out), .ic_done(ic_done), .pt_out(pt_out), .pt_valid(pt_valid),
    .pt_ready(pt_ready), .busy(busy), .err(err)
  );

  // ---------------- AES reference arithmetic ----------------
  logic [7:0] sb  [256];
  logic [7:0] isb [256];

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox_calc(input logic [7:0] v);
    logic [7:0] inv;
    inv = 8'h00;
    if (v != 8'h00) begin
      inv = 8'h01;
      for (int i = 0; i < 254; i++) inv = gmul(inv, v);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
               ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic int nr_tb(input logic [1:0] md);
    return (md == 2'd1) ? 12 : (md == 2'd2) ? 14 : 10;
  endfunction

  function automatic logic [127:0] aes_dec(input logic [255:0] key, input logic [1:0] md,
                                           input logic [127:0] ct);
    logic [31:0]  w [60];
    logic [31:0]  t;
    logic [7:0]   rc;
    logic [7:0]   s [16];
    logic [7:0]   u [16];
    logic [127:0] res;
    int nr, nk;
    nr = nr_tb(md);
    nk = nr - 6;
    for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
    rc = 8'h01;
    for (int i = nk; i < 4*(nr+1); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]} ^ {rc, 24'h0};
        rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
      end else if (nk > 6 && i % nk == 4) begin
        t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]};
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int b = 0; b < 16; b++) s[b] = ct[127-8*b -: 8] ^ w[4*nr + b/4][31-8*(b%4) -: 8];
    for (int r = nr - 1; r >= 0; r--) begin
      for (int b = 0; b < 16; b++) begin
        int row, col;
        row = b % 4;
        col = b / 4;
        u[b] = isb[s[4*((col - row + 4) % 4) + row]] ^ w[4*r + col][31-8*row -: 8];
      end
      for (int c = 0; c < 4; c++) begin
        if (r > 0) begin
          s[4*c]   = gmul(u[4*c],8'h0e) ^ gmul(u[4*c+1],8'h0b) ^ gmul(u[4*c+2],8'h0d) ^ gmul(u[4*c+3],8'h09);
          s[4*c+1] = gmul(u[4*c],8'h09) ^ gmul(u[4*c+1],8'h0e) ^ gmul(u[4*c+2],8'h0b) ^ gmul(u[4*c+3],8'h0d);
          s[4*c+2] = gmul(u[4*c],8'h0d) ^ gmul(u[4*c+1],8'h09) ^ gmul(u[4*c+2],8'h0e) ^ gmul(u[4*c+3],8'h0b);
          s[4*c+3] = gmul(u[4*c],8'h0b) ^ gmul(u[4*c+1],8'h0d) ^ gmul(u[4*c+2],8'h09) ^ gmul(u[4*c+3],8'h0e);
        end else begin
          for (int k = 0; k < 4; k++) s[4*c+k] = u[4*c+k];
        end
      end
    end
    for (int b = 0; b < 16; b++) res[127-8*b -: 8] = s[b];
    return res;
  endfunction

  // ---------------- datapath core stand-ins ----------------
  // Key schedule: counts up during the forward sweep (saturating at Nr),
  // down during the reverse sweep. inj_round forces an out-of-range value.
  logic [4:0] ke_rnd;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ke_rnd <= 5'd0;
    else if (ke_load) ke_rnd <= 5'd0;
    else if (!ke_rev && int'(ke_rnd) < nr_tb(ke_mode)) ke_rnd <= ke_rnd + 5'd1;
    else if (ke_rev && ke_rnd != 5'd0) ke_rnd <= ke_rnd - 5'd1;
  end
  assign ke_round = inj_round ? 5'd31 : ke_rnd;

  // Inverse cipher: one round per enabled cycle; flag after L rounds plus
  // the result register, optionally delayed by ic_extra, or never (ic_dead).
  logic [127:0] ic_res;
  logic [4:0]   ic_cnt;
  logic [4:0]   ic_nr;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ic_res <= '0; ic_cnt <= 5'd0; ic_nr <= 5'd10;
    end else if (ic_load) begin
      ic_res <= aes_dec(ke_key, ke_mode, ic_data);
      ic_cnt <= 5'd0;
      ic_nr  <= 5'(nr_tb(ke_mode));
    end else if (ic_en && ic_cnt != 5'd31) begin
      ic_cnt <= ic_cnt + 5'd1;
    end
  end
  assign ic_done = !ic_dead && ic_en && (ic_cnt == ic_nr + 5'd2 + 5'(ic_extra));
  assign ic_out  = ic_done ? ic_res : ~ic_res;

  // ---------------- checking ----------------
  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk_int(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: a job is a timeline counted in edges since accept.
  // Edge 0 -> key load, edges 1..L forward sweep, edge L+1 reverse start,
  // result at 2L+3+extra, or abandon at 2L+SLACK+2 if the core never answers.
  bit           m_busy, m_out, m_err, m_dead;
  int           m_j, m_L, m_extra;
  logic [1:0]   m_mode;
  logic [255:0] m_key;
  logic [127:0] m_ct, m_exp, m_pt_out;

  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        m_busy = 0; m_out = 0; m_err = 0; m_dead = 0; m_j = 0; m_L = 11; m_extra = 0;
        m_mode = 2'd0; m_key = '0; m_ct = '0; m_exp = '0; m_pt_out = '0;
      end
      chk("busy",        busy,        m_busy);
      chk("start_ready", start_ready, !m_busy);
      chk("ke_load",     ke_load,     m_busy && m_j == 0);
      chk("ic_load",     ic_load,     m_busy && m_j == 0);
      chk("ke_rev",      ke_rev,      m_busy && m_j >= m_L + 1);
      chk("ic_en",       ic_en,       m_busy && m_j >= m_L + 1 && !m_out);
      chk("pt_valid",    pt_valid,    m_out);
      chk("err",         err,         m_err);
      chk("pt_out",      pt_out,      m_pt_out);
      chk("ke_mode",     ke_mode,     m_mode);
      chk("ke_key",      ke_key,      m_key);
      chk("ic_data",     ic_data,     m_ct);
      if (rst_n) begin
        if (!m_busy) begin
          if (start) begin
            m_mode = mode_in; m_key = key_in; m_ct = ct_in;
            m_err = (mode_in == 2'd3);
            if (mode_in == 2'd3) begin
              $display("job rejected: illegal mode");
            end else begin
              m_busy = 1; m_j = 0; m_L = nr_tb(mode_in) + 1;
              m_extra = ic_extra; m_dead = ic_dead;
              m_exp = aes_dec(key_in, mode_in, ct_in);
            end
          end
        end else if (m_out) begin
          if (pt_ready) begin
            m_busy = 0; m_out = 0;
            $display("job done: mode=%0d pt=%h", m_mode, m_pt_out);
          end
        end else begin
          if (inj_round && m_j >= 1 && m_j <= m_L) m_err = 1;
          m_j++;
          if (!m_dead && m_j == 2*m_L + 3 + m_extra) begin
            m_out = 1; m_pt_out = m_exp;
          end else if (m_dead && m_j == 2*m_L + SLACK + 2) begin
            m_busy = 0; m_err = 1;
            $display("job timed out: mode=%0d", m_mode);
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  // Runs one job from posedge+1 to posedge+1; reports edge offsets (from the
  // accept edge) of first pt_valid, first ke_rev and return to idle.
  task automatic run_job(input logic [1:0] md, input logic [255:0] k, input logic [127:0] c,
                         input int extra, input bit dead, input int hold, input bit poke,
                         input int inj_at,
                         output int t_valid, output int t_rev, output int n_load, output int t_idle);
    int acc;
    t_valid = -1; t_rev = -1; n_load = 0; t_idle = -1;
    mode_in = md; key_in = k; ct_in = c; ic_extra = extra; ic_dead = dead;
    pt_ready = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    acc = cyc;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (ke_load) n_load++;
      if (ke_rev && t_rev < 0) t_rev = cyc - acc;
      if (pt_valid && t_valid < 0) t_valid = cyc - acc;
      if (start_ready) begin
        t_idle = cyc - acc;
        break;
      end
      @(posedge clk); #1;
      pt_ready  = (t_valid >= 0) && ((cyc - acc) - t_valid >= hold);
      start     = poke && (t_valid >= 0) && (cyc - acc == t_valid + 3);
      inj_round = (inj_at >= 0) && (cyc - acc == inj_at);
    end
    if (t_idle < 0) chk_int("job_bound", t_idle, 0);
    @(posedge clk); #1;
    pt_ready = 1'b0; start = 1'b0; inj_round = 1'b0;
  endtask

  initial begin
    int tv, tr, nl, ti;
    rst_n = 1'b0; start = 1'b0; mode_in = 2'd0; key_in = '0; ct_in = '0; pt_ready = 1'b0;
    for (int i = 0; i < 256; i++) sb[i] = sbox_calc(8'(i));
    for (int i = 0; i < 256; i++) isb[sb[i]] = 8'(i);

    // pin the reference arithmetic to published vectors
    chk("ref_aes128", aes_dec(K128, 2'd0, CT128), PT);
    chk("ref_aes192", aes_dec(K192, 2'd1, CT192), PT);
    chk("ref_aes256", aes_dec(K256, 2'd2, CT256), PT);

    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("reset_busy", busy, 0);
    chk("reset_ready", start_ready, 1);

    // AES-128 known answer
    run_job(2'd0, K128, CT128, 0, 0, 1, 0, -1, tv, tr, nl, ti);
    chk_int("lat128", tv, 25);
    chk("pt128", pt_out, PT);
    chk("err128", err, 0);

    // AES-256 known answer, strobe timing
    run_job(2'd2, K256, CT256, 0, 0, 1, 0, -1, tv, tr, nl, ti);
    chk_int("lat256", tv, 33);
    chk_int("rev_rise256", tr, 16);
    chk_int("ke_load_cycles256", nl, 1);
    chk("pt256", pt_out, PT);

    // illegal mode
    run_job(2'd3, K128, CT128, 0, 0, 1, 0, -1, tv, tr, nl, ti);
    chk("err_illegal", err, 1);
    chk_int("illegal_idle", ti, 0);
    chk_int("illegal_load", nl, 0);
    chk("illegal_ready", start_ready, 1);

    // dead core -> timeout after L+SLACK DEC cycles
    run_job(2'd0, K128, CT128, 0, 1, 1, 0, -1, tv, tr, nl, ti);
    chk_int("timeout_idle", ti, 28);
    chk_int("timeout_no_valid", tv, -1);
    chk("timeout_err", err, 1);

    // consumer stalls 10 cycles, start poked meanwhile
    run_job(2'd0, K128, CT128, 0, 0, 10, 1, -1, tv, tr, nl, ti);
    chk_int("stall_lat", tv, 25);
    chk("stall_pt", pt_out, PT);
    chk("stall_err_cleared", err, 0);

    // ic_done on the timeout cycle wins
    run_job(2'd0, K128, CT128, SLACK - 1, 0, 1, 0, -1, tv, tr, nl, ti);
    chk_int("boundary_lat", tv, 28);
    chk("boundary_err", err, 0);

    // schedule overrun during forward sweep flags err but completes
    run_job(2'd1, K192, CT192, 0, 0, 1, 0, 5, tv, tr, nl, ti);
    chk_int("overrun_lat", tv, 29);
    chk("overrun_err", err, 1);

    // asynchronous reset in the middle of the forward sweep
    mode_in = 2'd1; key_in = K192; ct_in = CT192; ic_extra = 0; ic_dead = 0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("async_busy", busy, 0);
    chk("async_rev", ke_rev, 0);
    chk("async_key", ke_key, 0);
    chk("async_data", ic_data, 0);
    chk("async_mode", ke_mode, 0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    run_job(2'd1, K192, CT192, 0, 0, 1, 0, -1, tv, tr, nl, ti);
    chk_int("post_reset_lat", tv, 29);
    chk("post_reset_pt", pt_out, PT);

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      if (start_ready) begin
        ic_dead  = ($urandom % 8 == 0);
        ic_extra = $urandom % SLACK;
      end
      start     = ($urandom % 3 == 0);
      mode_in   = ($urandom % 10 == 0) ? 2'd3 : 2'($urandom % 3);
      key_in    = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      ct_in     = {$urandom, $urandom, $urandom, $urandom};
      pt_ready  = ($urandom % 3 == 0);
      inj_round = ($urandom % 25 == 0);
      @(posedge clk); #1;
    end
    start = 1'b0; inj_round = 1'b0; pt_ready = 1'b1;
    for (int n = 0; n < 300 && !start_ready; n++) begin
      @(posedge clk); #1;
    end
    chk("drain_idle", start_ready, 1);
    @(posedge clk); #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
